// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding, requester ids and stats width for the UART TX arbiter
package uart_tx_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;
    localparam int STATS_W = 16;
endpackage

// File: rtl/uart_tx_arb_outreg.sv
// uart_tx_arb_outreg: single-entry registered output stage with valid/ready and source tag
module uart_tx_arb_outreg #(
    parameter int DW = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          load_src,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src
);
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          src_q, src_d;
    always_comb begin
        valid_d = load || (valid_q && !out_ready);
        data_d  = load ? load_data : data_q;
        src_d   = load ? load_src : src_q;
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter with burst limit feeding one UART TX sink; UART_TX_ARB_STATS_EN adds grant/byte counters
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int DW        = 8,
    parameter int MAX_BURST = 16,
    parameter int CNTW      = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          req0_valid,
    input  logic [DW-1:0] req0_data,
    input  logic          req0_last,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [DW-1:0] req1_data,
    input  logic          req1_last,
    output logic          req1_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_src,
    input  logic          out_ready,
    output logic          busy
`ifdef UART_TX_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0] grant_cnt0,
    output logic [STATS_W-1:0] grant_cnt1,
    output logic [STATS_W-1:0] byte_cnt
`endif
);
    state_e          state_q, state_d;
    logic            last_grant_q, last_grant_d;
    logic [CNTW-1:0] burst_cnt_q, burst_cnt_d;
    logic            can_load, acc0, acc1, acc, acc_src, acc_last, rel;
    logic [DW-1:0]   acc_data;
    assign can_load   = !out_valid || out_ready;
    assign req0_ready = (state_q == G0) && can_load;
    assign req1_ready = (state_q == G1) && can_load;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign acc        = acc0 || acc1;
    assign acc_src    = acc1 ? REQ_DBG : REQ_CPU;
    assign acc_data   = acc1 ? req1_data : req0_data;
    assign acc_last   = acc1 ? req1_last : req0_last;
    assign rel        = acc && (acc_last || (burst_cnt_q + CNTW'(1) == CNTW'(MAX_BURST)));
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        if (state_q == IDLE) begin
            state_d = (req0_valid && req1_valid) ? (last_grant_q ? G0 : G1) :
                      req0_valid ? G0 : req1_valid ? G1 : IDLE;
        end else if (rel) begin
            last_grant_d = acc_src;
            burst_cnt_d  = '0;
            state_d      = acc_src ? (req0_valid ? G0 : IDLE) : (req1_valid ? G1 : IDLE);
        end else if (acc) begin
            burst_cnt_d = burst_cnt_q + CNTW'(1);
        end
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end
    uart_tx_arb_outreg #(.DW(DW)) u_outreg (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .load      (acc),
        .load_data (acc_data),
        .load_src  (acc_src),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src)
    );
    assign busy = (state_q != IDLE) || out_valid;
`ifdef UART_TX_ARB_STATS_EN
    logic [STATS_W-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [STATS_W-1:0] grant_cnt1_q, grant_cnt1_d;
    logic [STATS_W-1:0] byte_cnt_q, byte_cnt_d;
    always_comb begin
        grant_cnt0_d = grant_cnt0_q + STATS_W'(state_d == G0 && state_q != G0);
        grant_cnt1_d = grant_cnt1_q + STATS_W'(state_d == G1 && state_q != G1);
        byte_cnt_d   = byte_cnt_q + STATS_W'(out_valid && out_ready);
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
            byte_cnt_q   <= '0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
            byte_cnt_q   <= byte_cnt_d;
        end
    end
    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign byte_cnt   = byte_cnt_q;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter against a packet-level arbitration model
module tb_uart_tx_arbiter;
    localparam int MB = 4;
    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       req0_valid = 1'b0, req0_last = 1'b0, req0_ready;
    logic [7:0] req0_data = '0;
    logic       req1_valid = 1'b0, req1_last = 1'b0, req1_ready;
    logic [7:0] req1_data = '0;
    logic       out_valid, out_src, busy;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
`ifdef UART_TX_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, byte_cnt;
`endif

    always #5 HCLK = ~HCLK;

    uart_tx_arbiter #(.DW(8), .MAX_BURST(MB), .CNTW(8)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .busy       (busy)
`ifdef UART_TX_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
        .byte_cnt   (byte_cnt)
`endif
    );

    typedef struct {logic [7:0] d; logic l;} ent_t;
    typedef struct {int cyc; logic src; logic [7:0] d;} cap_t;
    typedef struct {logic src; logic [7:0] d;} exp_t;
    typedef struct {logic v0; logic v1; logic r0; logic r1; logic b;} vec_t;

    ent_t q0[$], q1[$];
    cap_t cap[$];
    exp_t expq[$];
    int   errs = 0, checks = 0, cyc = 0, n_acc0 = 0;
    logic rnd_or = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req0_valid = q0.size() != 0;
        req0_data  = (q0.size() != 0) ? q0[0].d : 8'h00;
        req0_last  = (q0.size() != 0) ? q0[0].l : 1'b0;
        req1_valid = q1.size() != 0;
        req1_data  = (q1.size() != 0) ? q1[0].d : 8'h00;
        req1_last  = (q1.size() != 0) ? q1[0].l : 1'b0;
    endtask

    task automatic tick();
        logic h0, h1, ho;
        @(negedge HCLK);
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        ho = out_valid && out_ready;
        if (ho) cap.push_back('{cyc, out_src, out_data});
        @(posedge HCLK);
        #1;
        if (h0) begin
            void'(q0.pop_front());
            n_acc0++;
        end
        if (h1) void'(q1.pop_front());
        drive();
        if (rnd_or) out_ready = 1'($urandom_range(0, 1));
        cyc++;
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        q0.delete();
        q1.delete();
        cap.delete();
        drive();
        rnd_or = 1'b0;
        out_ready = 1'b1;
        n_acc0 = 0;
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc = 0;
    endtask

    task automatic add_pkt(input int r, input int len, input logic rnd, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            ent_t e;
            e.d = rnd ? 8'($urandom) : base + 8'(i);
            e.l = (i == len - 1);
            if (r == 0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    // Packet-level view: each grant drains up to MB bytes of one packet, then the other side goes if it has data.
    function automatic void model();
        ent_t a[$], b[$], e;
        int   cur, k;
        logic l;
        a = q0;
        b = q1;
        expq.delete();
        cur = (a.size() != 0) ? 0 : 1;
        while (a.size() + b.size() > 0) begin
            k = 0;
            do begin
                if (cur == 1) e = b.pop_front();
                else e = a.pop_front();
                expq.push_back('{cur[0], e.d});
                k++;
                l = e.l;
            end while (!l && k < MB && (cur == 1 ? b.size() : a.size()) > 0);
            if ((cur == 1 ? a.size() : b.size()) > 0) cur = 1 - cur;
        end
    endfunction

    task automatic run_check(input string name);
        int t = 0;
        model();
        drive();
        while (cap.size() < expq.size() && t < 3000) begin
            tick();
            t++;
        end
        chk({name, "_count"}, cap.size(), expq.size());
        foreach (expq[i])
            if (i < cap.size()) chk({name, "_byte"}, {cap[i].src, cap[i].d}, {expq[i].src, expq[i].d});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        logic [11:0] want_src;
        int t;
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);

        foreach (tbl[i]) begin
            do_reset();
            if (tbl[i].v0) add_pkt(0, 1, 1'b0, 8'h55);
            if (tbl[i].v1) add_pkt(1, 1, 1'b0, 8'h66);
            drive();
            tick();
            chk("tbl_req0_ready", req0_ready, tbl[i].r0);
            chk("tbl_req1_ready", req1_ready, tbl[i].r1);
            chk("tbl_busy", busy, tbl[i].b);
        end

        do_reset();
        add_pkt(0, 3, 1'b0, 8'h41);
        run_check("basic");
        for (int i = 0; i < 3 && i < cap.size(); i++) chk("basic_timing", cap[i].cyc, 2 + i);
        chk("basic_idle_busy", busy, 0);
        chk("basic_idle_ready", req0_ready, 0);

        do_reset();
        add_pkt(0, 1, 1'b0, 8'hA0);
        add_pkt(1, 1, 1'b0, 8'hB0);
        run_check("tie");
        if (cap.size() == 2) chk("tie_no_bubble", cap[1].cyc, cap[0].cyc + 1);

        do_reset();
        add_pkt(0, 10, 1'b0, 8'h00);
        add_pkt(1, 2, 1'b0, 8'h80);
        run_check("burst");
        want_src = 12'b0000_11_0000_00;
        for (int i = 0; i < 12 && i < cap.size(); i++) chk("burst_src", cap[i].src, want_src[11-i]);

        do_reset();
        out_ready = 1'b0;
        add_pkt(0, 3, 1'b0, 8'h10);
        drive();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ready", req0_ready, 0);
            chk("stall_data", {out_valid, out_data}, {1'b1, 8'h10});
        end
        out_ready = 1'b1;
        #1;
        chk("stall_release_ready", req0_ready, 1);
        tick();
        chk("stall_drain_load", {out_valid, out_data}, {1'b1, 8'h11});
        chk("stall_drained", cap.size() > 0 ? cap[0].d : 8'hXX, 8'h10);
        for (int i = 0; i < 4; i++) tick();

        do_reset();
        add_pkt(0, 5, 1'b0, 8'h60);
        drive();
        t = 0;
        while (n_acc0 < 2 && t < 20) begin
            tick();
            t++;
        end
        chk("midrst_accepted", n_acc0, 2);
        HRESETn = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", req0_ready, 0);
        q0.delete();
        cap.delete();
        drive();
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cyc = 0;
        add_pkt(1, 3, 1'b0, 8'h70);
        run_check("after_rst");

        for (int it = 0; it < 20; it++) begin
            do_reset();
            rnd_or = 1'b1;
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) add_pkt(0, int'($urandom_range(1, 9)), 1'b1, 8'h00);
            for (int p = 0; p < int'($urandom_range(0, 3)); p++) add_pkt(1, int'($urandom_range(1, 9)), 1'b1, 8'h00);
            run_check("random");
        end

`ifdef UART_TX_ARB_STATS_EN
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(0, 2, 1'b1, 8'h00);
        for (int p = 0; p < 2; p++) add_pkt(1, 2, 1'b1, 8'h00);
        run_check("stats");
        tick();
        chk("stats_grant0", grant_cnt0, 3);
        chk("stats_grant1", grant_cnt1, 2);
        chk("stats_bytes", byte_cnt, 10);
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
